// File: rtl/fir_pipe_param.sv
// Parametrised pipelined FIR engine: streams samples from a shared memory,
// filters them with loadable coefficients and writes one result per cycle.
module fir_pipe_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 5,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int unsigned SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        input_addr,
  input  logic [ADDR_W-1:0]        output_addr,
  input  logic [ADDR_W-1:0]        sample_count,
  input  logic                     round_en,
  input  logic                     sat_en,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_idx,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              cycle_count
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned V_W    = ACC_W + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [V_W-1:0]    RND   = (SHIFT > 0) ? (V_W'(1) << RND_SH) : '0;
  localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          n_q, n_d, rd_cnt_q, rd_cnt_d, wr_ptr_q, wr_ptr_d;
  logic                       round_q, round_d, sat_q, sat_d;
  logic [31:0]                cyc_q, cyc_d, cycle_count_q, cycle_count_d;
  logic                       vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;
  logic signed [COEF_W-1:0]   coef_q [TAPS];
  logic signed [COEF_W-1:0]   coef_d [TAPS];
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [DATA_W-1:0]   x_d [TAPS];
  logic signed [PROD_W-1:0]   prod_q [TAPS];
  logic signed [PROD_W-1:0]   prod_d [TAPS];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]          wr_data_q, wr_data_d;
  logic                       busy_q, busy_d, done_q, done_d;
  logic signed [V_W-1:0]      v_c, r_c;
  logic signed [DATA_W-1:0]   y_c;

  // Round, shift and saturate/wrap the accumulator into one output sample
  always_comb begin
    v_c = V_W'(acc_q) + (round_q ? RND : '0);
    r_c = v_c >>> SHIFT;
    y_c = DATA_W'(r_c);
    if (sat_q) begin
      if (r_c > V_W'(Y_MAX))      y_c = Y_MAX;
      else if (r_c < V_W'(Y_MIN)) y_c = Y_MIN;
    end
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    rd_cnt_d      = rd_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    round_d       = round_q;
    sat_d         = sat_q;
    cyc_d         = cyc_q;
    cycle_count_d = cycle_count_q;
    coef_d        = coef_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    vld1_d        = rd_en_q;
    vld2_d        = vld1_q;
    vld3_d        = vld2_q;

    // Delay line: x[0] is the newest sample
    x_d = x_q;
    if (vld1_q) begin
      x_d[0] = rd_data;
      for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
    end

    acc_d = '0;
    for (int i = 0; i < TAPS; i++) acc_d = acc_d + ACC_W'(prod_q[i]);

    if (vld3_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_ptr_q;
      wr_data_d = y_c;
      wr_ptr_d  = wr_ptr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (coef_we && (32'(coef_idx) < TAPS)) coef_d[coef_idx] = coef_data;
        if (start) begin
          n_d      = sample_count;
          round_d  = round_en;
          sat_d    = sat_en;
          wr_ptr_d = output_addr;
          cyc_d    = '0;
          for (int i = 0; i < TAPS; i++) x_d[i] = '0;
          if (sample_count == '0) begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            cycle_count_d = '0;
          end else begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = input_addr;
            rd_cnt_d  = ADDR_W'(1);
          end
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (rd_cnt_q < n_q) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cyc_d = cyc_q + 32'd1;
        // Last write is on the bus in cycle N+3
        if (cyc_q == 32'(n_q) + 32'd3) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          busy_d        = 1'b0;
          cycle_count_d = cyc_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < TAPS; i++) prod_d[i] = PROD_W'(coef_q[i]) * PROD_W'(x_d[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      rd_cnt_q      <= '0;
      wr_ptr_q      <= '0;
      round_q       <= 1'b0;
      sat_q         <= 1'b0;
      cyc_q         <= '0;
      cycle_count_q <= '0;
      vld1_q        <= 1'b0;
      vld2_q        <= 1'b0;
      vld3_q        <= 1'b0;
      acc_q         <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        x_q[i]    <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      round_q       <= round_d;
      sat_q         <= sat_d;
      cyc_q         <= cyc_d;
      cycle_count_q <= cycle_count_d;
      vld1_q        <= vld1_d;
      vld2_q        <= vld2_d;
      vld3_q        <= vld3_d;
      acc_q         <= acc_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      coef_q        <= coef_d;
      x_q           <= x_d;
      prod_q        <= prod_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_fir_pipe_param.sv
// Directed bench for fir_pipe_param: u_dut (SHIFT=0) and u_rnd (SHIFT=2)
// share one behavioural sample memory.
module tb_fir_pipe_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2, round_en, sat_en, coef_we, coef_we2;
  logic [9:0]  input_addr, output_addr, sample_count;
  logic [2:0]  coef_idx;
  logic [7:0]  coef_data;
  logic        rd_en, wr_en, busy, done, rd_en2, wr_en2, busy2, done2;
  logic [9:0]  rd_addr, wr_addr, rd_addr2, wr_addr2;
  logic [7:0]  rd_data, wr_data, rd_data2, wr_data2;
  logic [31:0] cycle_count, cycle_count2;

  logic signed [7:0] mem [1024];
  logic        tb_we, tb_clr;
  logic [9:0]  tb_addr;
  logic [7:0]  tb_wdata;
  int          rd_seen = 0, wr_seen = 0;
  int          rd_log [64];

  int n_cmp = 0, n_bad = 0;
  int dc, bz, r0, w0;
  int e_imp  [8]  = '{10, 20, 30, 20, 10, 0, 0, 0};
  int e_sat0 [10] = '{64, -64, -128, 0, 64, 64, 64, 64, 64, 64};
  int e_wrap [8]  = '{1, 3, 6, 8, 9, 9, 9, 9};

  always #5 clk = ~clk;

  fir_pipe_param #(.SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .input_addr(input_addr),
    .output_addr(output_addr), .sample_count(sample_count),
    .round_en(round_en), .sat_en(sat_en), .coef_we(coef_we),
    .coef_idx(coef_idx), .coef_data(coef_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  fir_pipe_param #(.SHIFT(2)) u_rnd (
    .clk(clk), .rst(rst), .start(start2), .input_addr(input_addr),
    .output_addr(output_addr), .sample_count(sample_count),
    .round_en(round_en), .sat_en(sat_en), .coef_we(coef_we2),
    .coef_idx(coef_idx), .coef_data(coef_data), .rd_en(rd_en2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .busy(busy2), .done(done2), .cycle_count(cycle_count2)
  );

  // Synchronous memory with one-cycle read latency, plus bench preload port
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= mem[rd_addr];
    if (rd_en2) rd_data2 <= mem[rd_addr2];
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_wdata;
    end
    if (wr_en)  mem[wr_addr]  <= wr_data;
    if (wr_en2) mem[wr_addr2] <= wr_data2;
    if (wr_en) wr_seen <= wr_seen + 1;
    if (rd_en) begin
      rd_seen <= rd_seen + 1;
      if (rd_seen < 64) rd_log[rd_seen] <= int'(rd_addr);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mem();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  task automatic put(input int a, input int v);
    tb_we = 1'b1; tb_addr = 10'(a); tb_wdata = 8'(v);
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_coef(input bit sel, input int idx, input int v);
    coef_idx = 3'(idx); coef_data = 8'(v);
    if (sel) coef_we2 = 1'b1; else coef_we = 1'b1;
    @(negedge clk);
    coef_we = 1'b0; coef_we2 = 1'b0;
  endtask

  // Start a run, optionally poke start/coef_we mid-run, wait for done (bounded)
  task automatic run(input bit sel, input int in_a, input int out_a, input int n,
                     input bit rnd, input bit sat, input int poke_start,
                     input int poke_coef, output int dcyc, output int bsy);
    int cyc;
    input_addr = 10'(in_a); output_addr = 10'(out_a); sample_count = 10'(n);
    round_en = rnd; sat_en = sat;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    cyc = 0; dcyc = -1; bsy = -1;
    while (cyc < 100) begin
      if (sel ? done2 : done) begin
        dcyc = cyc;
        bsy  = int'(sel ? busy2 : busy);
        break;
      end
      if (cyc == poke_start) begin
        output_addr = 10'd800;
        if (sel) start2 = 1'b1; else start = 1'b1;
      end
      if (cyc == poke_coef) begin
        coef_idx = 3'd0; coef_data = 8'd50;
        if (sel) coef_we2 = 1'b1; else coef_we = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; start2 = 1'b0; coef_we = 1'b0; coef_we2 = 1'b0;
      cyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; start2 = 1'b0; round_en = 1'b0; sat_en = 1'b0;
    coef_we = 1'b0; coef_we2 = 1'b0; coef_idx = '0; coef_data = '0;
    input_addr = '0; output_addr = '0; sample_count = '0;
    tb_we = 1'b0; tb_clr = 1'b0; tb_addr = '0; tb_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_cycle_count", int'(cycle_count), 0);
    rst = 1'b1;
    @(negedge clk);

    // Impulse response
    clr_mem();
    load_coef(0, 0, 1); load_coef(0, 1, 2); load_coef(0, 2, 3);
    load_coef(0, 3, 2); load_coef(0, 4, 1);
    put(0, 10);
    r0 = rd_seen; w0 = wr_seen;
    run(0, 0, 512, 8, 0, 0, -1, -1, dc, bz);
    chk("imp_done_cycle", dc, 12);
    chk("imp_busy_at_done", bz, 0);
    chk("imp_cycle_count", int'(cycle_count), 12);
    chk("imp_reads", rd_seen - r0, 8);
    chk("imp_writes", wr_seen - w0, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("imp[%0d]", i), int'(mem[512+i]), e_imp[i]);

    // Saturation and wrap modes
    for (int i = 0; i < 10; i++) put(i, 64);
    run(0, 0, 512, 10, 0, 1, -1, -1, dc, bz);
    for (int i = 0; i < 10; i++) chk($sformatf("sat1[%0d]", i), int'(mem[512+i]), (i == 0) ? 64 : 127);
    run(0, 0, 512, 10, 0, 0, -1, -1, dc, bz);
    for (int i = 0; i < 10; i++) chk($sformatf("sat0[%0d]", i), int'(mem[512+i]), e_sat0[i]);
    for (int i = 0; i < 10; i++) put(i, -128);
    run(0, 0, 512, 10, 0, 1, -1, -1, dc, bz);
    for (int i = 0; i < 10; i++) chk($sformatf("satneg[%0d]", i), int'(mem[512+i]), -128);

    // Rounding with SHIFT=2
    load_coef(1, 0, 1);
    put(100, 6); put(101, -6);
    run(1, 100, 700, 2, 1, 0, -1, -1, dc, bz);
    chk("rnd_done_cycle", dc, 6);
    chk("rnd1_pos", int'(mem[700]), 2);
    chk("rnd1_neg", int'(mem[701]), -1);
    run(1, 100, 700, 2, 0, 0, -1, -1, dc, bz);
    chk("rnd0_pos", int'(mem[700]), 1);
    chk("rnd0_neg", int'(mem[701]), -2);

    // Address wrap, start while busy ignored, back-to-back run
    clr_mem();
    for (int i = 0; i < 8; i++) put((1020 + i) % 1024, 1);
    r0 = rd_seen;
    run(0, 1020, 300, 8, 0, 0, 3, -1, dc, bz);
    chk("wrap_done_cycle", dc, 12);
    chk("wrap_reads", rd_seen - r0, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("wrap_rd_addr[%0d]", i), rd_log[r0+i], (1020 + i) % 1024);
    for (int i = 0; i < 8; i++) chk($sformatf("wrap_out[%0d]", i), int'(mem[300+i]), e_wrap[i]);
    chk("wrap_ignored_start", int'(mem[800]), 0);
    run(0, 1020, 600, 8, 0, 0, -1, -1, dc, bz);
    chk("b2b_done_cycle", dc, 12);
    for (int i = 0; i < 8; i++) chk($sformatf("b2b_out[%0d]", i), int'(mem[600+i]), e_wrap[i]);

    // N = 0
    r0 = rd_seen; w0 = wr_seen;
    run(0, 0, 0, 0, 0, 0, -1, -1, dc, bz);
    chk("n0_done_cycle", dc, 0);
    chk("n0_busy", bz, 0);
    chk("n0_cycle_count", int'(cycle_count), 0);
    chk("n0_reads", rd_seen - r0, 0);
    chk("n0_writes", wr_seen - w0, 0);

    // coef_we during a run is ignored; a following run still sees the old set
    clr_mem();
    put(0, 10);
    run(0, 0, 512, 5, 0, 0, -1, 1, dc, bz);
    run(0, 0, 520, 5, 0, 0, -1, -1, dc, bz);
    for (int i = 0; i < 5; i++) chk($sformatf("coefrun[%0d]", i), int'(mem[512+i]), e_imp[i]);
    for (int i = 0; i < 5; i++) chk($sformatf("coefnext[%0d]", i), int'(mem[520+i]), e_imp[i]);

    // Reset in cycle 5 of an N=20 run
    for (int i = 0; i < 20; i++) put(i, i + 1);
    input_addr = 10'd0; output_addr = 10'd900; sample_count = 10'd20;
    round_en = 1'b0; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_rd_en", int'(rd_en), 0);
    chk("mid_wr_en", int'(wr_en), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_cycle_count", int'(cycle_count), 0);
    w0 = wr_seen;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_writes", wr_seen - w0, 0);
    for (int i = 0; i < 4; i++) put(900 + i, 55);
    run(0, 0, 900, 4, 0, 0, -1, -1, dc, bz);
    chk("post_rst_done_cycle", dc, 8);
    chk("post_rst_cycle_count", int'(cycle_count), 8);
    for (int i = 0; i < 4; i++) chk($sformatf("post_rst_out[%0d]", i), int'(mem[900+i]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_pipe_param.md
Name: fir_pipe_param

Overview:
- Parametrised successor to the fixed 5-tap, 8-bit pipelined FIR engine inside fir_top.
- Streams sample_count signed samples from a shared sample memory starting at input_addr.
- Filters them with TAPS run-time-loadable coefficients through a 4-stage pipeline (read, multiply, sum, scale) and writes one result per cycle to output_addr.
- Adds configurable width/depth, coefficient load port, rounding and saturation modes, address wrap, and a cycle counter.

Parameters:
- DATA_W, 8, sample and result width (signed).
- COEF_W, 8, coefficient width (signed).
- TAPS, 5, filter length, 2..16.
- ADDR_W, 10, memory address width.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  run request, sampled in IDLE only
- input_addr  in  ADDR_W  first input sample address
- output_addr  in  ADDR_W  first result address
- sample_count  in  ADDR_W  number of samples N
- round_en  in  1  round-half-up before shift
- sat_en  in  1  saturate result (else wrap/truncate)
- coef_we  in  1  coefficient write strobe
- coef_idx  in  $clog2(TAPS)  coefficient index
- coef_data  in  COEF_W  coefficient value
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  DATA_W  read data, valid 1 cycle after rd_en
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- cycle_count  out  32  cycles of last run

Behaviour:
- Reset (rst=0, async): state IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr, wr_data = 0; cycle_count = 0; coefficients = 0; delay line and pipeline registers = 0; counters = 0.
- Reset asserted mid-run aborts the run immediately. No further writes occur. A new start is required.
- FSM: IDLE -> RUN (start=1 and N>0) -> DRAIN (after last read issued) -> DONE (after last write) -> IDLE.
- IDLE -> DONE directly when start=1 and N=0.
- At the start edge, latch input_addr, output_addr, N, round_en and sat_en. Clear the delay line to zero, so samples before input_addr count as 0. Set busy=1.
- Cycle numbering: cycle 0 is the first cycle after the start edge.
- Read issue: RUN asserts rd_en in cycles 0..N-1 with rd_addr = input_addr+k mod 2^ADDR_W.
- Per sample k, read in cycle k:
  - Cycle k+1: rd_data shifts into the delay line x[0..TAPS-1] at the end of the cycle.
  - Cycle k+2: products c_i*x_i are registered, full COEF_W+DATA_W width, signed.
  - Cycle k+3: acc = sum of products is registered, ACC_W wide, signed, no overflow.
  - Cycle k+4: wr_en=1, wr_addr = output_addr+k mod 2^ADDR_W, wr_data = scaled result.
- Scaling: v = acc + (round_en && SHIFT>0 ? 2^(SHIFT-1) : 0); r = v >>> SHIFT.
  - sat_en=1: clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat_en=0: take the low DATA_W bits of r.
- Throughput: one sample per cycle, no bubbles. Last write is in cycle N+3.
- Completion: done=1 and busy=0 in cycle N+4; cycle_count = N+4.
- For N=0: done in cycle 0 with cycle_count = 0 and no rd_en/wr_en pulses.
- cycle_count holds until the next accepted start.
- start while busy is ignored.
- coef_we is honoured only in IDLE; when busy it is ignored, so coefficients stay stable for a run. coef_idx >= TAPS is ignored.
- Input and output regions may overlap. Overlap is the caller's responsibility, and no hazard check is made.
- The addresses wrap modulo 2^ADDR_W independently.

Test Plan:
- Impulse: coefs [1,2,3,2,1], SHIFT=0, mem[0]=10, rest 0, N=8, out 512 -> mem[512..519] = 10,20,30,20,10,0,0,0; done in cycle 12; cycle_count=12.
- Saturation: coefs [1,2,3,2,1], mem[0..9]=64, N=10:
  - sat_en=1 -> outputs 64,127,127,127,127,...
  - sat_en=0 -> 64,192→-64,128→-128,0x40 wrap values (576 mod 256 = 64 at steady state).
  - Negative case: mem=-128, sat_en=1 -> steady -128.
- Rounding: SHIFT=2, coefs [1,0,0,0,0], samples 6,-6:
  - round_en=1 -> 2,-1.
  - round_en=0 -> 1,-2.
- Wrap and back-to-back: input_addr=1020, N=8 -> rd_addr sequence 1020..1023,0..3. A second start issued while busy is ignored; a start after done runs with new output_addr=600.
- Edge cases:
  - N=0 -> done in cycle 0, cycle_count=0, no memory strobes.
  - coef_we during RUN -> coefficients unchanged, outputs match the pre-run set.
- Reset mid-run: assert rst=0 at cycle 5 of an N=20 run -> busy, rd_en, wr_en, done drop at once; cycle_count=0; no writes after reset; a fresh start completes normally with zero-initialised coefficients (all outputs 0).
